uart_rx_os16: RTL
=================

Name: uart_rx_os16

Overview:
- 16x-oversampling UART receiver with an integrated baud tick generator, single clock domain.
- Serves as the far-end receiver for the team's uart_tx serial line, where the RX side runs from a free-running system clock rather than a dedicated baud clock.
- Recovers 8N1-style frames from an asynchronous RXD pin using majority-vote sampling and false-start rejection.
- Reports data-ready (active-low, NINTI style), framing error and overrun.

Parameters:
- CLK_DIV, 326: system clocks per oversample tick (baud = f_clk / (16*CLK_DIV)); legal range 2..65535.
- DATA_BITS, 8: data bits per frame, LSB first; legal 5..8.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous reset, active-low.
- RXD  input  1  serial line, idle high, asynchronous to CLOCK.
- ACK  input  1  one-cycle pulse: consumer has read RX_DATA.
- RX_DATA  output  DATA_BITS  last received byte.
- NINTI  output  1  active-low data-ready.
- FERR  output  1  framing error for the frame currently in RX_DATA.
- OVERRUN  output  1  sticky: a frame completed while NINTI was already low.

Behaviour:
- Reset (RESET=0, async): RX_DATA=0, NINTI=1, FERR=0, OVERRUN=0, state IDLE, tick/sample/bit counters 0, 2-flop RXD synchronizer preset to 1.
- Reset mid-frame aborts the frame; no partial data is delivered.
- Tick generator: free-running counter 0..CLK_DIV-1; tick asserts for one cycle when count==CLK_DIV-1, then wraps to 0.
  - Runs continuously, including in IDLE.
- Synchronized line rxs = second synchronizer flop; 2-cycle input latency.
- Sample counter sc (0..15) advances on each tick while not IDLE. Bit period = 16 ticks.
- Bit value = majority of rxs at sc=7, 8, 9; the vote is resolved on the sc=9 tick.
- FSM states:
  - IDLE: on any cycle rxs==0, go to START with sc=0 and tick counter cleared to 0 (aligns the bit grid to the edge).
  - START: at sc=9, vote=1 means false start, return to IDLE with no output change. Vote=0 continues; at sc=15 tick go to DATA, bit index 0.
  - DATA: vote at sc=9 shifts into the shift register, LSB first. At sc=15, after DATA_BITS bits, go to STOP; otherwise increment the bit index.
  - STOP: vote at sc=9, then the frame completes on that same tick and the FSM returns to IDLE, giving early resync for back-to-back frames.
- Frame completion, registered on the cycle after the completing tick:
  - RX_DATA <= shift register; NINTI <= 0; FERR <= ~stop_vote. Data is delivered even when FERR=1.
  - If NINTI was already 0 and ACK is not asserted that cycle, OVERRUN <= 1. RX_DATA is overwritten with the new frame.
- ACK without completion: NINTI <= 1, OVERRUN <= 0. FERR is held.
- ACK coincident with completion: the new frame wins; NINTI stays 0 and OVERRUN is not set (it is cleared).
- ACK while NINTI=1: no effect.
- FERR and RX_DATA change only on frame completion or reset.
- Receiver accepts a new start bit immediately after STOP sc=9. Consecutive frames need no idle gap.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, one bit period, sampled the same way.
  - Even parity is checked over the data bits.
  - Extra output port PERR (1 bit, reset 0) is set on completion to 1 if parity mismatched, else 0. It follows the same update rules as FERR.
- Undefined: no PARITY state, no PERR port; frame = start + DATA_BITS + stop.

Test Plan:
- CLK_DIV=4 (64 clk/bit), frame 0xA5 with stop=1 -> RX_DATA=0xA5, NINTI falls about 9.5 bit times after the start edge, FERR=0, OVERRUN=0. ACK pulse -> NINTI=1.
- RXD low pulse of 24 clocks (6 ticks) from idle -> FSM returns to IDLE. NINTI stays 1, RX_DATA unchanged.
- Frame 0x3C with stop bit driven 0 -> RX_DATA=0x3C, NINTI=0, FERR=1. Next good frame 0x11 -> FERR=0.
- Frames 0x55 then 0xAA back-to-back without ACK -> RX_DATA=0xAA, OVERRUN=1. ACK -> NINTI=1, OVERRUN=0.
- Assert RESET=0 during data bit 3 of a frame, release, then send 0x81 -> all outputs at reset values during reset, then RX_DATA=0x81, no FERR.
- With UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> PERR=1. 0x07 with parity bit 1 -> PERR=0. RX_DATA=0x07 in both cases.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver with built-in baud tick, majority-vote sampling and false-start rejection.
// Optional even-parity check and PERR output when UART_RX_PARITY_EN is defined.
module uart_rx_os16 #(
    parameter int CLK_DIV   = 326,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 RXD,
    input  logic                 ACK,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 NINTI,
    output logic                 FERR,
    output logic                 OVERRUN
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 PERR
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [15:0]            r_tick_cnt;
    logic                   r_sync1;
    logic                   r_sync2;
    logic [3:0]             r_sc;
    logic                   r_s7;
    logic                   r_s8;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
`endif

    logic w_rxs;
    logic w_tick;
    logic w_vote;
    logic w_mid;
    logic w_end;
    logic w_start;
    logic w_done;

    assign w_rxs   = r_sync2;
    assign w_tick  = (r_tick_cnt == 16'(CLK_DIV - 1));
    assign w_vote  = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);
    assign w_mid   = w_tick && (r_sc == 4'd9);
    assign w_end   = w_tick && (r_sc == 4'd15);
    assign w_start = (r_state == S_IDLE) && !w_rxs;
    assign w_done  = (r_state == S_STOP) && w_mid;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_rxs) w_next = S_START;
            S_START: begin
                if (w_mid && w_vote)  w_next = S_IDLE;
                else if (w_end)       w_next = S_DATA;
            end
            S_DATA: begin
                if (w_end && (r_bit_idx == 3'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_end) w_next = S_STOP;
            // Completing on the stop-bit vote lets the next start edge be caught early.
            S_STOP:   if (w_mid) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_tick_cnt <= '0;
            r_sc       <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            // Restarting the tick grid on the start edge centres the sc=7..9 samples in each bit.
            if (w_start || w_tick) r_tick_cnt <= '0;
            else                   r_tick_cnt <= r_tick_cnt + 16'd1;
            if (w_start)                            r_sc <= '0;
            else if (r_state != S_IDLE && w_tick)   r_sc <= r_sc + 4'd1;
            if (w_tick && r_sc == 4'd7) r_s7 <= w_rxs;
            if (w_tick && r_sc == 4'd8) r_s8 <= w_rxs;
            if (r_state == S_START)                 r_bit_idx <= '0;
            else if (r_state == S_DATA && w_end)    r_bit_idx <= r_bit_idx + 3'd1;
            if (r_state == S_DATA && w_mid)         r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_par_bit <= 1'b0;
            PERR      <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_mid) r_par_bit <= w_vote;
            if (w_done)                       PERR <= (^r_shift) ^ r_par_bit;
        end
    end
`endif

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            RX_DATA <= '0;
            NINTI   <= 1'b1;
            FERR    <= 1'b0;
            OVERRUN <= 1'b0;
        end else if (w_done) begin
            RX_DATA <= r_shift;
            NINTI   <= 1'b0;
            FERR    <= ~w_vote;
            if (ACK)         OVERRUN <= 1'b0;
            else if (!NINTI) OVERRUN <= 1'b1;
        end else if (ACK && !NINTI) begin
            NINTI   <= 1'b1;
            OVERRUN <= 1'b0;
        end
    end

endmodule
